// File: rtl/dp_ram_be.sv
// Simple dual-port RAM, one write port and one read port on one clock.
// Byte-enabled writes, 1- or 2-cycle read latency, selectable read-during-write result.
module dp_ram_be #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_collision
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dp_ram_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
    $error("dp_ram_be: DATA_W must be a non-zero multiple of 8");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("dp_ram_be: RDW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] rd_word;
  logic              collide;

  logic              s1_valid;
  logic              s1_coll;
  logic [DATA_W-1:0] s1_data;

  for (genvar b = 0; b < int'(NB); b++) begin : g_mask
    assign be_mask[8*b +: 8] = {8{wr_be[b]}};
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first bypass merges only the enabled bytes over the stored word.
  always_comb begin
    collide = wr_en && rd_en && (wr_addr == rd_addr);
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && collide) begin
      rd_word = (mem[rd_addr] & ~be_mask) | (wr_data & be_mask);
    end
  end

  // Fetch stage: data register only loads on an accepted read, so it doubles
  // as the holding output register when the latency is one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_coll  <= collide;
      if (rd_en) s1_data <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              out_valid;
    logic              out_coll;
    logic [DATA_W-1:0] out_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_coll  <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= s1_valid;
        out_coll  <= s1_valid && s1_coll;
        if (s1_valid) out_data <= s1_data;
      end
    end

    assign rd_data      = out_data;
    assign rd_valid     = out_valid;
    assign rd_collision = out_coll;
  end else begin : g_lat1
    assign rd_data      = s1_data;
    assign rd_valid     = s1_valid;
    assign rd_collision = s1_coll;
  end

endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench for dp_ram_be: four 32-bit instances (latency 1/2 x RDW mode 0/1)
// share one stimulus table; latency-2 expectations are the latency-1 ones one cycle later.
module tb_dp_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;

  logic [31:0] rd_data [4];
  logic        rd_valid [4];
  logic        rd_coll [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_ram_be #(.DATA_W(32), .ADDR_W(8), .RD_LATENCY(1), .RDW_MODE(0)) u_l1m0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_collision(rd_coll[0]));
  dp_ram_be #(.DATA_W(32), .ADDR_W(8), .RD_LATENCY(1), .RDW_MODE(1)) u_l1m1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_collision(rd_coll[1]));
  dp_ram_be #(.DATA_W(32), .ADDR_W(8), .RD_LATENCY(2), .RDW_MODE(0)) u_l2m0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .rd_collision(rd_coll[2]));
  dp_ram_be #(.DATA_W(32), .ADDR_W(8), .RD_LATENCY(2), .RDW_MODE(1)) u_l2m1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[3]), .rd_valid(rd_valid[3]), .rd_collision(rd_coll[3]));

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [7:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rd_en;
    logic [7:0]  ra;
    logic        v;
    logic        c;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic we, input logic [7:0] wa, input logic [3:0] be,
                     input logic [31:0] wd, input logic re, input logic [7:0] ra,
                     input logic v, input logic c, input logic [31:0] d0, input logic [31:0] d1);
    vec_t t;
    t.rst = r; t.wr_en = we; t.wa = wa; t.be = be; t.wd = wd;
    t.rd_en = re; t.ra = ra; t.v = v; t.c = c; t.d0 = d0; t.d1 = d1;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic v, input logic c,
                       input logic [31:0] d);
    checks++;
    if (rd_valid[idx] !== v || rd_coll[idx] !== c || rd_data[idx] !== d) begin
      errors++;
      $display("FAIL %s inst%0d: got valid=%b coll=%b data=%h, expected valid=%b coll=%b data=%h",
               name, idx, rd_valid[idx], rd_coll[idx], rd_data[idx], v, c, d);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; wr_en = t.wr_en; wr_addr = t.wa; wr_be = t.be; wr_data = t.wd;
    rd_en = t.rd_en; rd_addr = t.ra;
  endtask

  initial begin
    logic        pv, pc;
    logic [31:0] pd0, pd1;
    logic        e2v, e2c;
    logic [31:0] e2d0, e2d1;
    int          lat1, lat2;
    logic [31:0] d2;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;

    // rst we  waddr  be    wdata          re  raddr  v  c  d(mode0)       d(mode1)
    add(1, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'h0,        32'h0);
    add(1, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'h0,        32'h0);
    add(0, 1, 8'h10, 4'hF, 32'h0,         0, 8'h00, 0, 0, 32'h0,        32'h0);
    add(0, 1, 8'h10, 4'h1, 32'h000000A5,  0, 8'h00, 0, 0, 32'h0,        32'h0);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h10, 1, 0, 32'hA5,       32'hA5);
    add(0, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'hA5,       32'hA5);
    add(0, 1, 8'h30, 4'hF, 32'h11223344,  0, 8'h00, 0, 0, 32'hA5,       32'hA5);
    add(0, 1, 8'h30, 4'h5, 32'hAABBCCDD,  0, 8'h00, 0, 0, 32'hA5,       32'hA5);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h30, 1, 0, 32'h11BB33DD, 32'h11BB33DD);
    add(0, 1, 8'h20, 4'hF, 32'h0,         0, 8'h00, 0, 0, 32'h11BB33DD, 32'h11BB33DD);
    add(0, 1, 8'h20, 4'hC, 32'hFFFF0000,  1, 8'h20, 1, 1, 32'h0,        32'hFFFF0000);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h20, 1, 0, 32'hFFFF0000, 32'hFFFF0000);
    add(0, 1, 8'h21, 4'hF, 32'h12345678,  1, 8'h30, 1, 0, 32'h11BB33DD, 32'h11BB33DD);
    for (int a = 0; a < 8; a++)
      add(0, 1, 8'(a), 4'hF, 32'(a * 3),  0, 8'h00, 0, 0, 32'h11BB33DD, 32'h11BB33DD);
    for (int a = 0; a < 8; a++)
      add(0, 0, 8'h00, 4'h0, 32'h0,       1, 8'(a), 1, 0, 32'(a * 3),   32'(a * 3));
    add(0, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'd21,       32'd21);
    add(0, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'd21,       32'd21);
    add(0, 1, 8'h00, 4'hF, 32'hDEADBEEF,  0, 8'h00, 0, 0, 32'd21,       32'd21);
    add(0, 1, 8'hFF, 4'hF, 32'hCAFEF00D,  0, 8'h00, 0, 0, 32'd21,       32'd21);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h00, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'hFF, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++)
      add(0, 0, 8'h00, 4'h0, 32'h0,       0, 8'h00, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h30, 1, 0, 32'h11BB33DD, 32'h11BB33DD);
    add(1, 1, 8'h10, 4'hF, 32'h00000099,  1, 8'h10, 0, 0, 32'h0,        32'h0);
    add(0, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'h0,        32'h0);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h10, 1, 0, 32'hA5,       32'hA5);
    add(0, 1, 8'h10, 4'h0, 32'hFFFFFFFF,  0, 8'h00, 0, 0, 32'hA5,       32'hA5);
    add(0, 0, 8'h00, 4'h0, 32'h0,         1, 8'h10, 1, 0, 32'hA5,       32'hA5);
    add(0, 0, 8'h00, 4'h0, 32'h0,         0, 8'h00, 0, 0, 32'hA5,       32'hA5);

    pv = 1'b0; pc = 1'b0; pd0 = '0; pd1 = '0;
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      @(posedge clk);
      #1;
      // Latency 2 shows the previous cycle's latency-1 result unless reset hit this edge.
      if (vecs[k].rst) begin
        e2v = 1'b0; e2c = 1'b0; e2d0 = '0; e2d1 = '0;
      end else begin
        e2v = pv; e2c = pc; e2d0 = pd0; e2d1 = pd1;
      end
      check($sformatf("vec%0d_l1m0", k), 0, vecs[k].v, vecs[k].c, vecs[k].d0);
      check($sformatf("vec%0d_l1m1", k), 1, vecs[k].v, vecs[k].c, vecs[k].d1);
      check($sformatf("vec%0d_l2m0", k), 2, e2v, e2c, e2d0);
      check($sformatf("vec%0d_l2m1", k), 3, e2v, e2c, e2d1);
      pv = vecs[k].v; pc = vecs[k].c; pd0 = vecs[k].d0; pd1 = vecs[k].d1;
    end

    // Single isolated read: measure latency on both pipelines with a bounded wait.
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'hFF;
    lat1 = 0; lat2 = 0; d2 = '0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (rd_valid[0] === 1'b1 && lat1 == 0) lat1 = cyc;
      if (rd_valid[2] === 1'b1 && lat2 == 0) begin
        lat2 = cyc;
        d2 = rd_data[2];
      end
    end
    checks++;
    if (lat1 != 1) begin
      errors++;
      $display("FAIL latency1: got %0d cycles, expected 1 (0 = never valid)", lat1);
    end
    checks++;
    if (lat2 != 2) begin
      errors++;
      $display("FAIL latency2: got %0d cycles, expected 2 (0 = never valid)", lat2);
    end
    checks++;
    if (d2 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL latency2_data: got %h, expected cafef00d", d2);
    end
    check("post_idle_hold_l2", 2, 1'b0, 1'b0, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
